// File: rtl/dmem_responder_pkg.sv
package dmem_pkg;

  localparam int unsigned WORD_OFF_W = 2;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  typedef enum logic [1:0] {
    OP_LD,
    OP_ST,
    OP_ERR
  } op_t;

  // Misaligned or dual-strobe requests collapse into OP_ERR.
  function automatic op_t decode_op(input logic rd, input logic wr,
                                    input logic [WORD_OFF_W-1:0] off);
    if ((rd && wr) || (off != '0)) begin
      return OP_ERR;
    end else if (wr) begin
      return OP_ST;
    end else begin
      return OP_LD;
    end
  endfunction

endpackage

// File: rtl/dmem_responder_word_array.sv
module dmem_word_array
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned DATA_W = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         we,
  input  logic [ADDR_W-WORD_OFF_W-1:0] addr,
  input  logic [DATA_W-1:0]            wdata,
  output logic [DATA_W-1:0]            rdata
);

  localparam int unsigned IDX_W = ADDR_W - WORD_OFF_W;
  localparam int unsigned DEPTH = 1 << IDX_W;

  logic [DATA_W-1:0] mem [DEPTH];

  // Clear on reset has priority over any write at the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[IDX_W'(i)] <= '0;
      end
    end else if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/dmem_responder.sv
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_W      = 9,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] write_data,
  output logic [DATA_W-1:0] read_data,
  output logic              ready,
  output logic              err,
  output logic              busy
);

  localparam int unsigned IDX_W    = ADDR_W - WORD_OFF_W;
  localparam logic [3:0]  CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  state_t            state;
  state_t            state_nxt;
  logic [3:0]        cnt;
  logic [3:0]        cnt_nxt;
  logic              accept;
  logic              access;

  op_t               cap_op;
  logic [IDX_W-1:0]  cap_idx;
  logic [DATA_W-1:0] cap_data;

  logic              req;
  op_t               in_op;
  op_t               acc_op;
  logic [IDX_W-1:0]  acc_idx;
  logic [DATA_W-1:0] acc_data;
  logic [DATA_W-1:0] arr_rdata;
  logic              arr_we;

  assign req   = mem_read | mem_write;
  assign in_op = decode_op(mem_read, mem_write, addr[WORD_OFF_W-1:0]);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    access    = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          accept  = 1'b1;
          cnt_nxt = CNT_INIT;
          if (WAIT_CYCLES == 0) begin
            access    = 1'b1;
            state_nxt = RESP;
          end else begin
            state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt == '0) begin
          access    = 1'b1;
          state_nxt = RESP;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      RESP: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // With zero wait states the access happens at the accept edge, so the
  // live inputs are used instead of the not-yet-loaded capture registers.
  always_comb begin
    if (state == IDLE) begin
      acc_op   = in_op;
      acc_idx  = addr[ADDR_W-1:WORD_OFF_W];
      acc_data = write_data;
    end else begin
      acc_op   = cap_op;
      acc_idx  = cap_idx;
      acc_data = cap_data;
    end
  end

  assign arr_we = access && (acc_op == OP_ST);

  dmem_word_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_array (
    .clk   (clk),
    .reset (reset),
    .we    (arr_we),
    .addr  (acc_idx),
    .wdata (acc_data),
    .rdata (arr_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      cap_op    <= OP_LD;
      cap_idx   <= '0;
      cap_data  <= '0;
      read_data <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        cap_op   <= in_op;
        cap_idx  <= addr[ADDR_W-1:WORD_OFF_W];
        cap_data <= write_data;
      end
      if (access) begin
        case (acc_op)
          OP_LD:   read_data <= arr_rdata;
          OP_ERR:  read_data <= '0;
          default: ;
        endcase
      end
    end
  end

  assign ready = (state == RESP);
  assign err   = ready && (cap_op == OP_ERR);
  assign busy  = (state != IDLE);

endmodule
